// File: rtl/hm01b0_pixel_source.sv
// HM01B0 camera emulator: drives pixdata/pixclk/hsync/vsync with a selectable test pattern.
// Optional: define HM01B0_SRC_GATED_PIXCLK_EN to gate pixclk to active pixel periods only.
module hm01b0_pixel_source #(
  parameter int IMAGE_WIDTH    = 324,
  parameter int IMAGE_HEIGHT   = 244,
  parameter int HBLANK_PIXELS  = 16,
  parameter int VBLANK_LINES   = 4,
  parameter int CLKS_PER_PIXEL = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic [7:0] pixdata,
  output logic       pixclk,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_done,
  output logic       busy,
  output logic [7:0] frame_count
);

  localparam int LINE_PIXELS = IMAGE_WIDTH + HBLANK_PIXELS;
  localparam int Y_SPAN      = (IMAGE_HEIGHT > VBLANK_LINES) ? IMAGE_HEIGHT : VBLANK_LINES;
  localparam int PHASE_W     = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
  localparam int X_W         = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int Y_W         = (Y_SPAN > 1) ? $clog2(Y_SPAN) : 1;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLKS_PER_PIXEL - 1);
  localparam logic [PHASE_W-1:0] PHASE_HALF = PHASE_W'(CLKS_PER_PIXEL / 2);
  localparam logic [X_W-1:0]     X_LAST     = X_W'(LINE_PIXELS - 1);
  localparam logic [X_W-1:0]     X_ACTIVE   = X_W'(IMAGE_WIDTH);
  localparam logic [Y_W-1:0]     Y_ACT_LAST = Y_W'(IMAGE_HEIGHT - 1);
  localparam logic [Y_W-1:0]     Y_VB_LAST  = Y_W'(VBLANK_LINES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    VBLANK = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [PHASE_W-1:0] phase, phase_next;
  logic [X_W-1:0]     x, x_next;
  logic [Y_W-1:0]     y, y_next;
  logic [1:0]         pat_q, pat_next;

  logic [7:0] pixdata_next;
  logic       pixclk_next, hsync_next, vsync_next, frame_done_next, busy_next;
  logic       end_of_pixel, end_of_line, line_active, pixclk_high;
  logic [7:0] x8, y8, pattern_value;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_next   = state;
    phase_next   = phase;
    x_next       = x;
    y_next       = y;
    pat_next     = pat_q;
    end_of_pixel = (phase == PHASE_LAST);
    end_of_line  = end_of_pixel && (x == X_LAST);

    case (state)
      IDLE: begin
        if (enable) begin
          state_next = ACTIVE;
          phase_next = '0;
          x_next     = '0;
          y_next     = '0;
          pat_next   = pattern_sel;
        end
      end
      ACTIVE, VBLANK: begin
        phase_next = end_of_pixel ? '0 : phase + 1'b1;
        if (end_of_pixel) x_next = end_of_line ? '0 : x + 1'b1;
        if (end_of_line) begin
          if (state == ACTIVE) begin
            if (y == Y_ACT_LAST) begin
              state_next = VBLANK;
              y_next     = '0;
            end else begin
              y_next = y + 1'b1;
            end
          end else if (y == Y_VB_LAST) begin
            // Frame boundary: restart back to back, or park once enable has gone low.
            y_next = '0;
            if (enable) begin
              state_next = ACTIVE;
              pat_next   = pattern_sel;
            end else begin
              state_next = IDLE;
            end
          end else begin
            y_next = y + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs are registered from the current counters, so they trail the state by one cycle.
  always_comb begin
    x8          = 8'(x);
    y8          = 8'(y);
    line_active = (state == ACTIVE) && (x < X_ACTIVE);
    pixclk_high = (phase >= PHASE_HALF);

    case (pat_q)
      2'd0:    pattern_value = x8;
      2'd1:    pattern_value = y8;
      2'd2:    pattern_value = frame_count;
      default: pattern_value = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
    endcase

    vsync_next   = (state == ACTIVE);
    hsync_next   = line_active;
    pixdata_next = line_active ? pattern_value : 8'h00;
`ifdef HM01B0_SRC_GATED_PIXCLK_EN
    pixclk_next  = line_active && pixclk_high;
`else
    pixclk_next  = (state != IDLE) && pixclk_high;
`endif
    frame_done_next = (state == VBLANK) && (y == '0) && (x == '0) && (phase == '0);
    busy_next       = (state_next != IDLE);
  end

  always_ff @(posedge clock) begin
    // NOTE: reset is sampled on the clock edge only; it is deliberately absent from the sensitivity list.
    if (!reset) begin
      state       <= IDLE;
      phase       <= '0;
      x           <= '0;
      y           <= '0;
      pat_q       <= '0;
      pixdata     <= '0;
      pixclk      <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state      <= state_next;
      phase      <= phase_next;
      x          <= x_next;
      y          <= y_next;
      pat_q      <= pat_next;
      pixdata    <= pixdata_next;
      pixclk     <= pixclk_next;
      hsync      <= hsync_next;
      vsync      <= vsync_next;
      frame_done <= frame_done_next;
      busy       <= busy_next;
      if (frame_done_next) frame_count <= frame_count + 8'd1;
    end
  end

endmodule
